// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle 4-register CPU (8-bit ISA) with a single-port memory handshake.
// Latency: ALU/branch 2 cycles, LOAD/STORE 3 cycles with zero-wait memory, plus wait states.
// Backpressure: mem_ready, out_ready and in_valid stall the FSM; request fields held stable meanwhile.
// Ports: clk, rst (async active-low); mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready;
//        out_valid/out_data/out_ready; in_ready/in_data/in_valid; halted, illegal, pc, instret.
// Optional: define CPU_INSTRET_EN to build the retired-instruction counter (instret reads 0 otherwise).
module mc_cpu_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              halted,
   output logic              illegal,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       instret
);

   typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_IO, S_HALT} state_t;

   state_t            state, state_nxt;
   logic              run;          // low during reset and the first cycle after, so no request escapes reset
   logic [7:0]        ir;
   logic [DATA_W-1:0] regs [4];
   logic [ADDR_W-1:0] pc_q;
   logic              illegal_q;
   logic              retire;

   logic [3:0]        op;
   logic [1:0]        rd_sel, rs_sel;
   logic [DATA_W-1:0] rd_val, rs_val;
   logic [ADDR_W-1:0] pc_inc1, pc_inc2;
   logic              is_halt, is_ls, is_store, is_io, io_out;

   assign op       = ir[7:4];
   assign rd_sel   = ir[3:2];
   assign rs_sel   = ir[1:0];
   assign rd_val   = regs[rd_sel];
   assign rs_val   = regs[rs_sel];
   assign pc_inc1  = pc_q + ADDR_W'(1);
   assign pc_inc2  = pc_q + ADDR_W'(2);
   assign is_halt  = (op == 4'b0000) && (rs_sel == 2'd1);
   assign is_ls    = (op == 4'b0010) || (op == 4'b0011);
   assign is_store = (op == 4'b0011);
   assign is_io    = (op == 4'b1000) && rs_sel[1];
   assign io_out   = (rs_sel == 2'd2);

   assign pc       = pc_q;
   assign illegal  = illegal_q;
   assign halted   = (state == S_HALT);
   // Rd cannot change while OUT is pending, so out_data is stable for the whole handshake.
   assign out_data = rd_val;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_FETCH;
         run   <= 1'b0;
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
      end
   end

   // Next state and handshake outputs. The memory address in MEM comes from R[Rs],
   // which is not written until the transfer completes, so it is stable across waits.
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      mem_wdata = rd_val;
      out_valid = 1'b0;
      in_ready  = 1'b0;
      retire    = 1'b0;
      unique case (state)
         S_FETCH: begin
            mem_req = run;
            if (run && mem_ready) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (is_halt) begin
               state_nxt = S_HALT;
               retire    = 1'b1;
            end else if (is_ls) begin
               state_nxt = S_MEM;
            end else if (is_io) begin
               state_nxt = S_IO;
            end else begin
               state_nxt = S_FETCH;
               retire    = 1'b1;
            end
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = is_store;
            mem_addr = ADDR_W'(rs_val);
            if (mem_ready) begin
               state_nxt = S_FETCH;
               retire    = 1'b1;
            end
         end
         S_IO: begin
            if (io_out) begin
               out_valid = 1'b1;
               if (out_ready) begin
                  state_nxt = S_FETCH;
                  retire    = 1'b1;
               end
            end else begin
               in_ready = 1'b1;
               if (in_valid) begin
                  state_nxt = S_FETCH;
                  retire    = 1'b1;
               end
            end
         end
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_FETCH;
      endcase
   end

   // Datapath: IR, register file, PC, sticky illegal flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir        <= 8'h00;
         pc_q      <= RESET_PC;
         illegal_q <= 1'b0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         unique case (state)
            S_FETCH: begin
               if (run && mem_ready) ir <= mem_rdata[7:0];
            end
            S_EXEC: begin
               pc_q <= pc_inc1;
               case (op)
                  4'b0000: if (is_halt) pc_q <= pc_q;
                  4'b0001: regs[rd_sel] <= rd_val - rs_val;
                  4'b0111: regs[rd_sel] <= rd_val + rs_val;
                  4'b0110: regs[rd_sel] <= ~(rd_val & rs_val);
                  4'b0100: begin
                     if (((rs_sel == 2'd0) && (rd_val == '0)) ||
                         ((rs_sel == 2'd1) && (rd_val != '0)))
                        pc_q <= pc_inc2;
                  end
                  4'b0101: begin
                     // Non-blocking: the jump target is R[Rs] before the link write, even if Rd==Rs.
                     pc_q         <= ADDR_W'(rs_val);
                     regs[rd_sel] <= DATA_W'(pc_inc1);
                  end
                  4'b1000: begin
                     if (rs_sel == 2'd0) regs[rd_sel] <= rd_val + DATA_W'(1);
                     if (rs_sel == 2'd1) regs[rd_sel] <= rd_val - DATA_W'(1);
                  end
                  4'b1001, 4'b1010, 4'b1011: illegal_q <= 1'b1;
                  4'b1100, 4'b1101, 4'b1110, 4'b1111:
                     regs[rd_sel] <= {rd_val[DATA_W-5:0], ir[5:4], ir[1:0]};
                  default: ;  // LOAD/STORE: work done in MEM
               endcase
            end
            S_MEM: begin
               if (mem_ready && !is_store) regs[rd_sel] <= mem_rdata;
            end
            S_IO: begin
               if (!io_out && in_valid) regs[rd_sel] <= in_data;
            end
            default: ;
         endcase
      end
   end

`ifdef CPU_INSTRET_EN
   logic [31:0] instret_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        instret_q <= 32'd0;
      else if (retire) instret_q <= instret_q + 32'd1;
   end
   assign instret = instret_q;
`else
   assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: directed self-checking bench for mc_cpu_core (DATA_W=8, ADDR_W=8).
// Holds a 256-byte memory model reloaded from an image during each reset.
// Programs build register values with SLI, then check registers, PC, status and handshakes.
module tb_mc_cpu_core;

`ifdef CPU_INSTRET_EN
   localparam bit IRET = 1'b1;
`else
   localparam bit IRET = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mem_req, mem_we, mem_ready;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       out_valid, out_ready, in_ready, in_valid;
   logic [7:0] out_data, in_data;
   logic       halted, illegal;
   logic [7:0] pc;
   logic [31:0] instret;

   logic [7:0] mem [256];
   logic [7:0] img [256];
   logic       do_load = 1'b0;

   int checks = 0;
   int errors = 0;
   int waited = 0;

   mc_cpu_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .in_ready(in_ready), .in_data(in_data), .in_valid(in_valid),
      .halted(halted), .illegal(illegal), .pc(pc), .instret(instret)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (do_load) mem <= img;
      else if (mem_req && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 256; i++) img[i] = v;
   endtask

   task automatic start();
      rst = 1'b0; do_load = 1'b1;
      mem_ready = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(negedge clk);
      do_load = 1'b0; rst = 1'b1;
   endtask

   task automatic wait_fetch(input logic [7:0] a, input string tag);
      bit found = 1'b0;
      waited = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk); waited++;
         if (mem_req && !mem_we && mem_addr == a) found = 1'b1;
      end
      checks++;
      assert (found) else begin
         errors++;
         $error("FAIL %s: fetch of %h observed=none expected=seen within %0d cycles", tag, a, waited);
      end
   endtask

   task automatic wait_halt(input string tag);
      int n = 0;
      while (!halted && n < 300) begin @(negedge clk); n++; end
      checks++;
      assert (halted === 1'b1) else begin
         errors++;
         $error("FAIL %s: halted observed %b expected 1 after %0d cycles", tag, halted, n);
      end
   endtask

   task automatic run_skip(input bit r3_one, input logic [7:0] op, input logic [7:0] exp_pc,
                           input string tag);
      fill(8'h01);
      for (int i = 0; i < 5; i++) img[i] = 8'h00;
      if (r3_one) img[0] = 8'hCD;  // SLI R3,1
      img[5] = op;
      start();
      wait_halt(tag);
      chk(tag, pc, exp_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation observed no finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- Reset state and SLI/HALT program ----
      fill(8'h01);
      img[0] = 8'hD9; img[1] = 8'hD9; img[2] = 8'h01;
      rst = 1'b0; do_load = 1'b1; mem_ready = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_pc", pc, 0);
      chk("rst_instret", instret, 0);
      do_load = 1'b0; rst = 1'b1;
      wait_halt("sli_halt");
      chk("sli_r2", dut.regs[2], 8'h55);
      chk("sli_pc", pc, 8'h02);
      chk("sli_illegal", illegal, 0);
      chk("sli_instret", instret, IRET ? 3 : 0);
      repeat (3) @(negedge clk);
      chk("halt_pc_hold", pc, 8'h02);
      chk("halt_no_req", mem_req, 0);

      // ---- SUB / ADD wrap, ALU latency ----
      fill(8'h01);
      img[0] = 8'hC5; img[1] = 8'h11; img[2] = 8'h71; img[3] = 8'h01;
      start();
      wait_fetch(8'h02, "sub_fetch");
      chk("sub_r0", dut.regs[0], 8'hFF);
      wait_fetch(8'h03, "add_fetch");
      chk("alu_latency", waited, 2);
      chk("add_r0_wrap", dut.regs[0], 8'h00);
      wait_halt("add_halt");
      chk("add_pc", pc, 8'h03);

      // ---- SKIPZ / SKIPNZ ----
      run_skip(1'b0, 8'h4C, 8'h07, "skipz_r3_0");
      run_skip(1'b1, 8'h4C, 8'h06, "skipz_r3_1");
      run_skip(1'b0, 8'h4D, 8'h06, "skipnz_r3_0");
      run_skip(1'b1, 8'h4D, 8'h07, "skipnz_r3_1");

      // ---- JALR ----
      fill(8'h01);
      img[0] = 8'hD8; img[1] = 8'hC8;
      for (int i = 2; i < 16; i++) img[i] = 8'h00;
      img[16] = 8'h56;
      start();
      wait_halt("jalr_halt");
      chk("jalr_pc", pc, 8'h40);
      chk("jalr_r1", dut.regs[1], 8'h11);
      chk("jalr_r2", dut.regs[2], 8'h40);

      // ---- STORE / LOAD with 3 wait states each ----
      fill(8'h01);
      img[0] = 8'hE2; img[1] = 8'hD1; img[2] = 8'hE4; img[3] = 8'hC4;
      img[4] = 8'h31; img[5] = 8'h29; img[6] = 8'h01;
      start();
      wait_fetch(8'h04, "st_fetch");
      @(negedge clk);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("st_req", mem_req, 1);
         chk("st_we", mem_we, 1);
         chk("st_addr", mem_addr, 8'h80);
         chk("st_wdata", mem_wdata, 8'hA5);
      end
      mem_ready = 1'b1;
      wait_fetch(8'h05, "ld_fetch");
      chk("st_mem", mem[8'h80], 8'hA5);
      @(negedge clk);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ld_req", mem_req, 1);
         chk("ld_we", mem_we, 0);
         chk("ld_addr", mem_addr, 8'h80);
         chk("ld_r2_unchanged", dut.regs[2], 8'h00);
      end
      mem_ready = 1'b1;
      wait_halt("ls_halt");
      chk("ld_r2", dut.regs[2], 8'hA5);
      chk("ls_pc", pc, 8'h06);

      // ---- OUT with delayed ready, illegal opcode, IN ----
      fill(8'h01);
      img[0] = 8'hC7; img[1] = 8'hF4; img[2] = 8'h86; img[3] = 8'h90; img[4] = 8'h8F; img[5] = 8'h01;
      start();
      wait_fetch(8'h02, "out_fetch");
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("out_valid_hold", out_valid, 1);
         chk("out_data", out_data, 8'h3C);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("out_next_fetch", mem_addr, 8'h03);
      wait_fetch(8'h04, "ill_fetch");
      chk("illegal_set", illegal, 1);
      in_data = 8'h77;
      repeat (2) @(negedge clk);
      chk("in_ready", in_ready, 1);
      @(negedge clk);
      chk("in_ready_hold", in_ready, 1);
      chk("in_r3_unchanged", dut.regs[3], 8'h00);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("in_ready_drop", in_ready, 0);
      wait_halt("io_halt");
      chk("in_r3", dut.regs[3], 8'h77);
      chk("io_pc", pc, 8'h05);
      chk("illegal_sticky", illegal, 1);
      chk("io_instret", instret, IRET ? 6 : 0);

      // ---- Reset asserted mid-FETCH ----
      fill(8'h01);
      img[0] = 8'h90; img[1] = 8'hC5;
      start();
      wait_fetch(8'h01, "mid_fetch");
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_req_stall", mem_req, 1);
      chk("mid_illegal", illegal, 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_illegal", illegal, 0);
      chk("mid_rst_halted", halted, 0);
      chk("mid_rst_pc", pc, 0);
      chk("mid_rst_instret", instret, 0);
      chk("mid_rst_out", out_valid, 0);
      chk("mid_rst_in", in_ready, 0);
      chk("mid_rst_r1", dut.regs[1], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
